spi_dac_scheduler: RTL and testbench
====================================

# spi_dac_scheduler

Sequences and shares the single DAC SPI port (`spi_dac_*`, `dac_rst_export`) between several on-chip requesters, such as CPU varset writes and the closed-loop feedback path. It runs the power-up DAC reset pulse, grants requesters round-robin, and serializes one word per grant onto SPI. It sits between the requester logic and the DAC pins, in place of a direct CPU SPI connection.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WORD_W`, 24: SPI word length in bits, sent MSB first.
- `CLK_DIV`, 4: SCLK half-period in `clk_clk` cycles (≥2).
- `RST_CYC`, 100: cycles `dac_rst_export` is held after reset release.
- `GAP_CYC`, 4: minimum SS_n-high cycles between words.
---
- `clk_clk`  in  1  single system clock.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request; `req_data` must be held stable while high.
- `req_data`  in  NREQ*WORD_W  word for requester i at bits [i*WORD_W +: WORD_W].
- `req_ready`  out  NREQ  one-hot grant; the word transfers on a cycle where valid&ready.
- `done`  out  NREQ  one-cycle pulse for the granted requester when its word completes.
- `rdata`  out  WORD_W  word captured on MISO during the last transaction.
- `busy`  out  1  high outside IDLE.
- `dac_rst_export`  out  1  active-high DAC reset.
- `spi_dac_SCLK`, `spi_dac_MOSI`, `spi_dac_SS_n`  out  1  SPI master pins.
- `spi_dac_MISO`  in  1  SPI readback input.

## Operation
- Reset values:
  - `dac_rst_export`=1, `busy`=1.
  - `SS_n`=1, `SCLK`=0, `MOSI`=0.
  - `req_ready`=0, `done`=0, `rdata`=0.
  - RR pointer=0, state=DACRST.
- DACRST: hold for RST_CYC cycles, then go to IDLE; `dac_rst_export` and `busy` drop on the same edge.
- IDLE:
  - The winner is the first valid requester searching from the pointer upward, with wrap-around.
  - `req_ready[winner]` is combinational, asserted only in IDLE.
  - On the handshake: latch the word, set pointer = winner+1 mod NREQ, go to SETUP.
  - If no request is valid, stay in IDLE. Dropping `valid` before the grant is legal and produces no grant.
- SETUP: `SS_n`=0, `SCLK`=0, `MOSI`=word MSB, held for CLK_DIV cycles.
- SHIFT: WORD_W SCLK periods.
  - SCLK rises after each low half-period; MISO is sampled on the rising edge.
  - MOSI advances on the falling edge (CPOL=0, CPHA=0).
  - SCLK ends low.
- HOLD: `SS_n`=0 for CLK_DIV cycles, then `SS_n` rises. `done[granted]` pulses on the cycle `SS_n` rises, and `rdata` updates on that cycle.
- GAP: `SS_n`=1 for GAP_CYC cycles, then return to IDLE.
- Async reset at any point aborts the transfer: pins return to reset values, no `done` is issued, and DACRST reruns. Pending requests are re-arbitrated from pointer 0.

## Timing
- With the grant on cycle t, `SS_n` falls at t+1.
- `SS_n` rises and `done` pulses at t+1+CLK_DIV+2·WORD_W·CLK_DIV+CLK_DIV.
- The next grant comes no earlier than GAP_CYC cycles later.
- Defaults: `done` at t+201; next grant at t+205.
- All outputs except `req_ready` are registered. Grant latency from `valid` rising in IDLE is 0 cycles.

## Configuration
- `SPI_DAC_READBACK_EN`:
  - Defined: the MISO shift register is built, and `rdata` holds the sampled word, MSB first.
  - Undefined: no capture logic is built, `rdata` is tied to 0, and `spi_dac_MISO` is ignored.

## Structure
- Package `spi_dac_sched_pkg`: state enum (DACRST, IDLE, SETUP, SHIFT, HOLD, GAP) and default parameter constants.
- Sub-module `spi_dac_shifter`: divider tick, bit counter, MOSI/MISO shift registers.
- The top level holds the arbiter, the pointer and the sequencing FSM.

## Test plan
- Reset release: `dac_rst_export`=1 for exactly 100 cycles, then 0. `busy` falls on the same cycle. `SS_n` stays 1 throughout.
- Single transfer: `req_valid[0]` with 0x3F1234.
  - Grant at t; `SS_n` low t+1..t+200.
  - 24 SCLK rising edges; MOSI bits equal 0x3F1234 MSB first.
  - `done[0]` at t+201.
- Arbitration: all four valid at once gives grants 0,1,2,3. Then re-assert only 0 and 2: grants 0, then 2. No grant is given within 4 cycles after `SS_n` rises.
- Reset mid-SHIFT:
  - Asserting `reset_reset_n`=0 immediately forces `SS_n`=1, `SCLK`=0, and no `done`.
  - After 100 cycles of DACRST, the still-pending request is granted.
- Readback:
  - With `SPI_DAC_READBACK_EN`, MISO drives 0xA5A5A5 and `rdata`=0xA5A5A5 at the `done` pulse.
  - Without the macro, `rdata` stays 0.
- Withdrawn request: `req_valid[1]` pulses during requester 0's SHIFT and drops before IDLE; requester 1 is never granted.

Source files
------------

// File: rtl/spi_dac_scheduler_pkg.sv
// spi_dac_sched_pkg: state encoding, default parameters and the round-robin pointer helper
// shared by the DAC SPI scheduler files.
package spi_dac_sched_pkg;

   localparam int DEF_NREQ    = 4;
   localparam int DEF_WORD_W  = 24;
   localparam int DEF_CLK_DIV = 4;
   localparam int DEF_RST_CYC = 100;
   localparam int DEF_GAP_CYC = 4;

   typedef enum logic [2:0] {
      ST_DACRST = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_HOLD   = 3'd4,
      ST_GAP    = 3'd5
   } sched_state_e;

   // Plain-vector aliases so the state register stays a logic vector.
   localparam logic [2:0] S_DACRST = ST_DACRST;
   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_SETUP  = ST_SETUP;
   localparam logic [2:0] S_SHIFT  = ST_SHIFT;
   localparam logic [2:0] S_HOLD   = ST_HOLD;
   localparam logic [2:0] S_GAP    = ST_GAP;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 == n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/spi_dac_scheduler_if.sv
// spi_dac_scheduler_if: requester handshake bundle (valid/data in, one-hot ready/done out).
interface spi_dac_scheduler_if import spi_dac_sched_pkg::*; #(
   parameter int NREQ   = DEF_NREQ,
   parameter int WORD_W = DEF_WORD_W
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*WORD_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        done;

   modport master (output req_valid, output req_data, input req_ready, input done);
   modport slave  (input req_valid, input req_data, output req_ready, output done);
endinterface

// File: rtl/spi_dac_shifter.sv
// spi_dac_shifter: SCLK divider tick, bit counter and MOSI/MISO shift registers (CPOL=0, CPHA=0).
// MISO capture exists only when SPI_DAC_READBACK_EN is defined.
module spi_dac_shifter import spi_dac_sched_pkg::*; #(
   parameter int WORD_W  = DEF_WORD_W,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_run,
   input  logic              i_shift,
   input  logic              i_miso,
   output logic              o_tick,
   output logic              o_last,
   output logic              o_sclk,
   output logic              o_mosi,
   output logic [WORD_W-1:0] o_rx
);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(WORD_W);

   logic [DIV_W-1:0]  r_div;
   logic [BIT_W-1:0]  r_bit;
   logic              r_sclk;
   logic [WORD_W-1:0] r_tx;

   assign o_tick = (r_div == DIV_W'(CLK_DIV - 1));
   assign o_last = i_shift & o_tick & r_sclk & (r_bit == BIT_W'(WORD_W - 1));
   assign o_sclk = r_sclk;
   assign o_mosi = r_tx[WORD_W-1];

   // Divider free-runs through SETUP/SHIFT/HOLD; in SHIFT each tick toggles SCLK, falling edge shifts MOSI.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div  <= '0;
         r_bit  <= '0;
         r_sclk <= 1'b0;
         r_tx   <= '0;
      end else if (i_load) begin
         r_div  <= '0;
         r_bit  <= '0;
         r_sclk <= 1'b0;
         r_tx   <= i_word;
      end else if (i_run) begin
         r_div <= o_tick ? '0 : r_div + 1'b1;
         if (i_shift && o_tick) begin
            if (r_sclk) begin
               r_sclk <= 1'b0;
               r_bit  <= r_bit + 1'b1;
               r_tx   <= {r_tx[WORD_W-2:0], 1'b0};
            end else begin
               r_sclk <= 1'b1;
            end
         end
      end
   end

`ifdef SPI_DAC_READBACK_EN
   logic [WORD_W-1:0] r_rx;

   // MISO is captured on the same tick that raises SCLK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx <= '0;
      end else if (i_load) begin
         r_rx <= '0;
      end else if (i_run && i_shift && o_tick && !r_sclk) begin
         r_rx <= {r_rx[WORD_W-2:0], i_miso};
      end
   end

   assign o_rx = r_rx;
`else
   logic w_miso_unused;
   assign w_miso_unused = i_miso;
   assign o_rx          = '0;
`endif

endmodule

// File: rtl/spi_dac_scheduler.sv
// spi_dac_scheduler: DAC reset sequencing, round-robin arbitration and one SPI word per grant.
// Optional MISO readback into rdata is enabled by defining SPI_DAC_READBACK_EN.
module spi_dac_scheduler import spi_dac_sched_pkg::*; #(
   parameter int NREQ    = DEF_NREQ,
   parameter int WORD_W  = DEF_WORD_W,
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int RST_CYC = DEF_RST_CYC,
   parameter int GAP_CYC = DEF_GAP_CYC
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   spi_dac_scheduler_if.slave  bus,
   output logic [WORD_W-1:0]   rdata,
   output logic                busy,
   output logic                dac_rst_export,
   output logic                spi_dac_SCLK,
   output logic                spi_dac_MOSI,
   output logic                spi_dac_SS_n,
   input  logic                spi_dac_MISO
);
   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(RST_CYC + GAP_CYC + 1);
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [PTR_W-1:0]  r_ptr;
   logic [PTR_W-1:0]  r_gnt;
   logic              r_ss_n;
   logic              r_busy;
   logic              r_dac_rst;
   logic [NREQ-1:0]   r_done;

   logic              w_found;
   logic [PTR_W-1:0]  w_winner;
   logic [NREQ-1:0]   w_ready;
   logic              w_load;
   logic              w_run;
   logic              w_shift;
   logic              w_tick;
   logic              w_last;
   logic              w_sclk;
   logic              w_mosi;
   logic [WORD_W-1:0] w_word;
   logic [WORD_W-1:0] w_rx;

   // Round-robin search: first valid requester at or above the pointer, wrapping around.
   always_comb begin
      int j;
      j        = 0;
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(r_ptr) + k;
         j = (j >= NREQ) ? j - NREQ : j;
         if (!w_found && bus.req_valid[PTR_W'(j)]) begin
            w_found  = 1'b1;
            w_winner = PTR_W'(j);
         end else begin
            w_winner = w_winner;
         end
      end
   end

   assign w_load  = (r_state == S_IDLE) && w_found;
   assign w_ready = w_load ? (ONE << w_winner) : '0;
   assign w_run   = (r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD);
   assign w_shift = (r_state == S_SHIFT);
   assign w_word  = bus.req_data[int'(w_winner)*WORD_W +: WORD_W];

   spi_dac_shifter #(
      .WORD_W  (WORD_W),
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .i_load  (w_load),
      .i_word  (w_word),
      .i_run   (w_run),
      .i_shift (w_shift),
      .i_miso  (spi_dac_MISO),
      .o_tick  (w_tick),
      .o_last  (w_last),
      .o_sclk  (w_sclk),
      .o_mosi  (w_mosi),
      .o_rx    (w_rx)
   );

   // Sequencer: DAC reset pulse, grant handshake, SPI frame phases and the inter-word gap.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state   <= S_DACRST;
         r_cnt     <= '0;
         r_ptr     <= '0;
         r_gnt     <= '0;
         r_ss_n    <= 1'b1;
         r_busy    <= 1'b1;
         r_dac_rst <= 1'b1;
         r_done    <= '0;
      end else begin
         r_done <= '0;
         case (r_state)
            S_DACRST: begin
               if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                  r_state   <= S_IDLE;
                  r_cnt     <= '0;
                  r_dac_rst <= 1'b0;
                  r_busy    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (w_load) begin
                  r_state <= S_SETUP;
                  r_gnt   <= w_winner;
                  r_ptr   <= PTR_W'(rr_next(int'(w_winner), NREQ));
                  r_ss_n  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_SETUP: begin
               if (w_tick) begin
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_last) begin
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (w_tick) begin
                  r_state <= S_GAP;
                  r_ss_n  <= 1'b1;
                  r_done  <= ONE << r_gnt;
               end
            end
            S_GAP: begin
               if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= S_DACRST;
               r_cnt     <= '0;
               r_ss_n    <= 1'b1;
               r_busy    <= 1'b1;
               r_dac_rst <= 1'b1;
            end
         endcase
      end
   end

`ifdef SPI_DAC_READBACK_EN
   logic [WORD_W-1:0] r_rdata;

   // Readback word becomes visible together with the done pulse.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_rdata <= '0;
      end else if ((r_state == S_HOLD) && w_tick) begin
         r_rdata <= w_rx;
      end
   end

   assign rdata = r_rdata;
`else
   logic w_rx_unused;
   assign w_rx_unused = |w_rx;
   assign rdata       = '0;
`endif

   assign bus.req_ready  = w_ready;
   assign bus.done       = r_done;
   assign busy           = r_busy;
   assign dac_rst_export = r_dac_rst;
   assign spi_dac_SS_n   = r_ss_n;
   assign spi_dac_SCLK   = w_sclk;
   assign spi_dac_MOSI   = w_mosi;

endmodule

// File: tb/tb_spi_dac_scheduler.sv
// Scoreboard bench for spi_dac_scheduler: requests are predicted by a round-robin model into a
// queue; a monitor checks grants, SPI framing, MOSI bits, timing and readback at each done pulse.
module tb_spi_dac_scheduler;
   localparam int N  = 4;
   localparam int W  = 24;
   localparam int CD = 4;
   localparam int RC = 100;
   localparam int GC = 4;
   localparam int LAT = 1 + CD + 2 * W * CD + CD;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dac_rst, busy, sclk, mosi, ss_n, miso;
   logic [W-1:0] rdata;

   spi_dac_scheduler_if #(.NREQ(N), .WORD_W(W)) bus ();

   spi_dac_scheduler #(
      .NREQ(N), .WORD_W(W), .CLK_DIV(CD), .RST_CYC(RC), .GAP_CYC(GC)
   ) dut (
      .clk_clk        (clk),
      .reset_reset_n  (rst_n),
      .bus            (bus),
      .rdata          (rdata),
      .busy           (busy),
      .dac_rst_export (dac_rst),
      .spi_dac_SCLK   (sclk),
      .spi_dac_MOSI   (mosi),
      .spi_dac_SS_n   (ss_n),
      .spi_dac_MISO   (miso)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           id;
      logic [W-1:0] word;
      logic [W-1:0] miso;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int mdl_ptr = 0;
   int exp_grants = 0;
   int grants = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   // Reference arbitration: each held request is served in round-robin order from the model pointer.
   task automatic issue(input logic [N-1:0] mask, input logic [N*W-1:0] words);
      logic [N-1:0] m;
      exp_t e;
      bit f;
      int idx;
      m = mask;
      while (m != '0) begin
         f = 1'b0;
         for (int k = 0; k < N; k++) begin
            idx = (mdl_ptr + k) % N;
            if (!f && m[idx]) begin
               f = 1'b1;
               e.id = idx;
               e.word = words[idx*W +: W];
               e.miso = W'($urandom);
               exp_q.push_back(e);
               m[idx] = 1'b0;
               mdl_ptr = (idx + 1) % N;
               exp_grants++;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (mask[i]) bus.req_data[i*W +: W] = words[i*W +: W];
      end
      bus.req_valid = bus.req_valid | mask;
   endtask

   task automatic wait_drain();
      int budget;
      budget = 300 * exp_q.size() + 200;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (GC + 2) @(posedge clk);
      #1;
   endtask

   task automatic wait_sclk();
      for (int k = 0; k < 500; k++) begin
         @(posedge clk);
         #1;
         if (sclk) break;
      end
      chk("sclk_seen", 32'(sclk), 32'd1);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Requesters drop valid right after their word has been accepted.
   initial begin
      logic [N-1:0] clr;
      forever begin
         @(negedge clk);
         clr = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         bus.req_valid = bus.req_valid & ~clr;
      end
   end

   // Monitor / scoreboard
   logic mon_en = 1'b0;
   logic prev_ss = 1'b1;
   logic prev_sclk = 1'b0;
   int grant_cyc = 0;
   int last_done_cyc = -1000;
   int sclk_cnt = 0;
   int ss_low = 0;
   logic [W-1:0] mosi_word;
   logic [W-1:0] miso_sh;
   logic [W-1:0] exp_rd;
   logic [N-1:0] hs;
   exp_t e;

   always @(negedge clk) begin
      if (mon_en) begin
         hs = bus.req_valid & bus.req_ready;
         if (hs != '0) begin
            grants++;
            if (exp_q.size() == 0) begin
               chk("unexpected_grant", 32'(hs), 32'd0);
            end else begin
               chk("grant_id", 32'(hs), 32'(1) << exp_q[0].id);
               chk("grant_gap", 32'(cyc - last_done_cyc >= GC), 32'd1);
               miso_sh = exp_q[0].miso;
               miso = miso_sh[W-1];
            end
            grant_cyc = cyc;
            sclk_cnt = 0;
            ss_low = 0;
            mosi_word = '0;
         end
         if (!ss_n) ss_low++;
         if (prev_ss && !ss_n) chk("ss_fall_time", 32'(cyc - grant_cyc), 32'd1);
         if (!prev_sclk && sclk) begin
            sclk_cnt++;
            mosi_word = {mosi_word[W-2:0], mosi};
         end
         if (prev_sclk && !sclk) begin
            miso_sh = miso_sh << 1;
            miso = miso_sh[W-1];
         end
         if (bus.done != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
               e = exp_q.pop_front();
`ifdef SPI_DAC_READBACK_EN
               exp_rd = e.miso;
`else
               exp_rd = '0;
`endif
               chk("done_id", 32'(bus.done), 32'(1) << e.id);
               chk("mosi_word", 32'(mosi_word), 32'(e.word));
               chk("sclk_edges", 32'(sclk_cnt), 32'(W));
               chk("ss_low_cycles", 32'(ss_low), 32'(LAT - 1));
               chk("done_latency", 32'(cyc - grant_cyc), 32'(LAT));
               chk("ss_high_at_done", 32'(ss_n), 32'd1);
               chk("rdata", 32'(rdata), 32'(exp_rd));
            end
            last_done_cyc = cyc;
         end
         prev_ss = ss_n;
         prev_sclk = sclk;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [N*W-1:0] wv;
      logic [N-1:0] mask;
      int n;
      bit ss_ok;
      bus.req_valid = '0;
      bus.req_data = '0;
      miso = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dac_rst", 32'(dac_rst), 32'd1);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ss_n", 32'(ss_n), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      ss_ok = 1'b1;
      for (int k = 0; k < RC + 20; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (!ss_n || sclk) ss_ok = 1'b0;
         if (!dac_rst) break;
      end
      chk("dac_rst_cycles", 32'(n), 32'(RC));
      chk("busy_falls_with_rst", 32'(busy), 32'd0);
      chk("ss_high_in_dacrst", 32'(ss_ok), 32'd1);
      mon_en = 1'b1;

      // Single transfer from requester 0
      wv = '0;
      wv[0 +: W] = 24'h3F1234;
      issue(4'b0001, wv);
      wait_drain();
      chk("idle_busy", 32'(busy), 32'd0);

      // All four, then only 0 and 2
      for (int i = 0; i < N; i++) wv[i*W +: W] = W'($urandom);
      issue(4'b1111, wv);
      wait_drain();
      for (int i = 0; i < N; i++) wv[i*W +: W] = W'($urandom);
      issue(4'b0101, wv);
      wait_drain();

      // Requester 1 pulses valid during requester 0's shift and withdraws
      for (int i = 0; i < N; i++) wv[i*W +: W] = W'($urandom);
      issue(4'b0001, wv);
      wait_sclk();
      bus.req_data[W +: W] = W'($urandom);
      bus.req_valid[1] = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      bus.req_valid[1] = 1'b0;
      wait_drain();
      repeat (20) @(posedge clk);
      #1;
      chk("withdrawn_grants", 32'(grants), 32'(exp_grants));

      // Randomized batches
      for (int b = 0; b < 8; b++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) wv[i*W +: W] = W'($urandom);
         issue(mask, wv);
         wait_drain();
      end

      // Reset in the middle of requester 2's shift with 1 and 3 pending
      for (int i = 0; i < N; i++) wv[i*W +: W] = W'($urandom);
      issue(4'b0100, wv);
      wait_sclk();
      bus.req_data[1*W +: W] = wv[1*W +: W];
      bus.req_data[3*W +: W] = wv[3*W +: W];
      bus.req_valid = bus.req_valid | 4'b1010;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      mon_en = 1'b0;
      #1;
      chk("abort_ss_n", 32'(ss_n), 32'd1);
      chk("abort_sclk", 32'(sclk), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_dac_rst", 32'(dac_rst), 32'd1);
      exp_q.delete();
      mdl_ptr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      prev_ss = 1'b1;
      prev_sclk = 1'b0;
      last_done_cyc = -1000;
      issue(4'b1010, wv);
      mon_en = 1'b1;
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < RC + 20; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.req_ready != '0) break;
      end
      chk("regrant_after_dacrst", 32'(n), 32'(RC));
      wait_drain();
      chk("grant_count", 32'(grants), 32'(exp_grants));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
